// File: rtl/key_event_decoder.sv
// Scancode-to-key-event decoder: per-slot stability filter, autorepeat, release
// detection and a shared most-recent-key register. All outputs are registered.
module key_event_decoder #(
    parameter int NUM_KEYS     = 4,
    parameter int CODE_W       = 8,
    parameter int FILTER       = 2,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000,
    localparam int IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [CODE_W-1:0]            i_char,
    input  logic [NUM_KEYS*CODE_W-1:0]   i_codes,
    input  logic [NUM_KEYS-1:0]          i_repeat_en,
    output logic [NUM_KEYS-1:0]          o_press,
    output logic [NUM_KEYS-1:0]          o_release,
    output logic [NUM_KEYS-1:0]          o_held,
    output logic                         o_any_press,
    output logic [IDX_W-1:0]             o_last_key,
    output logic                         o_last_valid
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
    localparam int QUAL_W  = $clog2(FILTER + 1);

    localparam logic [QUAL_W-1:0] FILTER_Q   = QUAL_W'(FILTER);
    localparam logic [RPT_W-1:0]  DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]  RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    state_t              state_q   [NUM_KEYS];
    state_t              state_d   [NUM_KEYS];
    logic [QUAL_W-1:0]   qual_q    [NUM_KEYS];
    logic [QUAL_W-1:0]   qual_d    [NUM_KEYS];
    logic [RPT_W-1:0]    rpt_q     [NUM_KEYS];
    logic [RPT_W-1:0]    rpt_d     [NUM_KEYS];
    logic [NUM_KEYS-1:0] phase_q;
    logic [NUM_KEYS-1:0] phase_d;

    logic [NUM_KEYS-1:0] match_s;
    logic [NUM_KEYS-1:0] press_q,   press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] held_q,    held_d;
    logic                any_q,     any_d;
    logic [IDX_W-1:0]    last_key_q, last_key_d;
    logic                last_valid_q, last_valid_d;

    // Slot match: a zero code can never match because a zero char means no key.
    always_comb begin
        match_s = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            match_s[k] = (i_char == i_codes[k*CODE_W +: CODE_W]) && (i_char != '0);
        end
    end

    // Per-slot next state, filter/repeat counters and event pulses.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        held_d    = '0;
        phase_d   = phase_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            qual_d[k]  = qual_q[k];
            rpt_d[k]   = rpt_q[k];
            case (state_q[k])
                ST_IDLE: begin
                    if (match_s[k] && (FILTER == 1)) begin
                        state_d[k] = ST_HELD;
                        press_d[k] = 1'b1;
                        rpt_d[k]   = '0;
                        phase_d[k] = 1'b0;
                    end else if (match_s[k]) begin
                        state_d[k] = ST_QUAL;
                        qual_d[k]  = QUAL_W'(1);
                    end else begin
                        qual_d[k]  = '0;
                    end
                end
                ST_QUAL: begin
                    if (match_s[k] && ((qual_q[k] + QUAL_W'(1)) == FILTER_Q)) begin
                        state_d[k] = ST_HELD;
                        press_d[k] = 1'b1;
                        qual_d[k]  = '0;
                        rpt_d[k]   = '0;
                        phase_d[k] = 1'b0;
                    end else if (match_s[k]) begin
                        qual_d[k]  = qual_q[k] + QUAL_W'(1);
                    end else begin
                        state_d[k] = ST_IDLE;
                        qual_d[k]  = '0;
                    end
                end
                ST_HELD: begin
                    // Release is checked first so it always wins over a due repeat.
                    if (!match_s[k]) begin
                        state_d[k]   = ST_IDLE;
                        release_d[k] = 1'b1;
                        rpt_d[k]     = '0;
                        phase_d[k]   = 1'b0;
                    end else if (!i_repeat_en[k]) begin
                        rpt_d[k]     = '0;
                        phase_d[k]   = 1'b0;
                    end else if (rpt_q[k] == (phase_q[k] ? RATE_LAST : DELAY_LAST)) begin
                        press_d[k]   = 1'b1;
                        rpt_d[k]     = '0;
                        phase_d[k]   = 1'b1;
                    end else begin
                        rpt_d[k]     = rpt_q[k] + RPT_W'(1);
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    qual_d[k]  = '0;
                    rpt_d[k]   = '0;
                    phase_d[k] = 1'b0;
                end
            endcase
            held_d[k] = (state_d[k] == ST_HELD);
        end
    end

    // Most-recent-key tracking; scanning downward leaves the lowest pressed index.
    always_comb begin
        any_d        = |press_d;
        last_key_d   = last_key_q;
        last_valid_d = last_valid_q | any_d;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (press_d[k]) begin
                last_key_d = IDX_W'(k);
            end else begin
                last_key_d = last_key_d;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
                qual_q[k]  <= '0;
                rpt_q[k]   <= '0;
            end
            phase_q      <= '0;
            press_q      <= '0;
            release_q    <= '0;
            held_q       <= '0;
            any_q        <= 1'b0;
            last_key_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                qual_q[k]  <= qual_d[k];
                rpt_q[k]   <= rpt_d[k];
            end
            phase_q      <= phase_d;
            press_q      <= press_d;
            release_q    <= release_d;
            held_q       <= held_d;
            any_q        <= any_d;
            last_key_q   <= last_key_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign o_press      = press_q;
    assign o_release    = release_q;
    assign o_held       = held_q;
    assign o_any_press  = any_q;
    assign o_last_key   = last_key_q;
    assign o_last_valid = last_valid_q;

endmodule
